// File: rtl/img_buf_writer_if.sv
// img_buf_writer_if: camera stream in, buffer write port and frame handshake out.
// Modports: master drives the stream and ack, slave is the buffer writer.
interface img_buf_writer_if #(
  parameter int PIX_W = 8,
  parameter int BA_W  = 14
);
  logic             frame_start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             frame_ack;
  logic             buf_we;
  logic [BA_W-1:0]  buf_addr;
  logic [PIX_W-1:0] buf_wdata;
  logic             frame_ready;
  logic             rd_bank;
  logic             busy;
  logic             overrun;

  modport master (
    output frame_start, pix_valid, pix_data, frame_ack,
    input  buf_we, buf_addr, buf_wdata,
    input  frame_ready, rd_bank, busy, overrun
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, frame_ack,
    output buf_we, buf_addr, buf_wdata,
    output frame_ready, rd_bank, busy, overrun
  );
endinterface

// File: rtl/img_buf_writer.sv
// img_buf_writer: writes the raster pixel stream into the image buffer RAM.
// Ports: clk, rst_n, bus (slave). Option macro BUF_PINGPONG_EN adds a second bank.
module img_buf_writer #(
  parameter int IMG_W  = 112,
  parameter int IMG_H  = 112,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input logic             clk,
  input logic             rst_n,
  img_buf_writer_if.slave bus
);
`ifdef BUF_PINGPONG_EN
  localparam int   BA_W = ADDR_W + 1;
  localparam logic PP   = 1'b1;
`else
  localparam int   BA_W = ADDR_W;
  localparam logic PP   = 1'b0;
`endif
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, waddr;
  logic [1:0]         full_q, full_d;
  logic               wb_q, wb_d;
  logic               rd_q, rd_d;
  logic               we_d, ovr_d, restart;
  logic               we_q, ovr_q, rdy_q;
  logic [BA_W-1:0]    wa, addr_o;
  logic [PIX_W-1:0]   wdata_o;

`ifdef BUF_PINGPONG_EN
  assign wa = {wb_q, waddr};
`else
  assign wa = waddr;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    waddr   = addr_q;
    full_d  = full_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    we_d    = 1'b0;
    ovr_d   = 1'b0;
    restart = 1'b0;
    // full bits mark banks awaiting ack; rd_q is always the oldest
    if (bus.frame_ack && (|full_q)) begin
      full_d[rd_q] = 1'b0;
      rd_d = rd_q ^ PP;
    end
    if (bus.frame_start) begin
      if (state_q == CAPTURE) begin
        ovr_d   = 1'b1;
        restart = 1'b1;
      end else if (!full_d[wb_q]) begin
        restart = 1'b1;
        state_d = CAPTURE;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (restart) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end
    if (bus.pix_valid && (state_d == CAPTURE)) begin
      we_d  = 1'b1;
      waddr = addr_d;
      if (row_d == RW'(IMG_H - 1) && col_d == CW'(IMG_W - 1)) begin
        full_d[wb_q] = 1'b1;
        wb_d = wb_q ^ PP;
        state_d = full_d[wb_q ^ PP] ? READY : IDLE;
      end else begin
        addr_d = addr_d + 1'b1;
        if (col_d == CW'(IMG_W - 1)) begin
          col_d = '0;
          row_d = row_d + 1'b1;
        end else begin
          col_d = col_d + 1'b1;
        end
      end
    end else if (state_d != CAPTURE) begin
      state_d = full_d[wb_q] ? READY : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      full_q  <= '0;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      ovr_q   <= 1'b0;
      rdy_q   <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ovr_q   <= ovr_d;
      // ready only once a bank has been full for a whole cycle,
      // so it trails the final write by one cycle
      rdy_q   <= |(full_q & full_d);
      if (we_d) begin
        addr_o  <= wa;
        wdata_o <= bus.pix_data;
      end
    end
  end

  assign bus.buf_we      = we_q;
  assign bus.buf_addr    = addr_o;
  assign bus.buf_wdata   = wdata_o;
  assign bus.frame_ready = rdy_q;
  assign bus.rd_bank     = rd_q;
  assign bus.busy        = (state_q == CAPTURE);
  assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_img_buf_writer.sv
// tb_img_buf_writer: random and directed stimulus, queue scoreboard
// against a pixel-count reference model of img_buf_writer.
module tb_img_buf_writer;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 14;
`ifdef BUF_PINGPONG_EN
  localparam int BA_W  = ADDR_W + 1;
  localparam int NBANK = 2;
`else
  localparam int BA_W  = ADDR_W;
  localparam int NBANK = 1;
`endif
  localparam int NPIX = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  img_buf_writer_if #(.PIX_W(PIX_W), .BA_W(BA_W)) bus();

  img_buf_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [BA_W-1:0] addr;
    logic [PIX_W-1:0] data;
  } wr_t;

  typedef struct {
    int cyc;
    bit fr;
    bit busy;
    bit ovr;
    bit rdb;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  wr_t mw;
  st_t ms;

  // reference model: frame = NPIX accepted pixels, linear index = address
  bit m_cap;
  int m_n;
  int m_wb;
  int m_acks;
  int pend_vis[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_cap = 0;
    m_n = 0;
    m_wb = 0;
    m_acks = 0;
    pend_vis.delete();
    wq.delete();
    sq.delete();
  endfunction

  function automatic void model_step(bit fs, bit pv, logic [PIX_W-1:0] pd,
                                     bit ack, int k);
    bit ovr;
    bit fr;
    ovr = 0;
    fr = 0;
    if (ack && pend_vis.size() > 0) begin
      void'(pend_vis.pop_front());
      m_acks++;
    end
    if (fs) begin
      if (m_cap) begin
        ovr = 1;
        m_n = 0;
      end else if (pend_vis.size() < NBANK) begin
        m_cap = 1;
        m_n = 0;
      end else begin
        ovr = 1;
      end
    end
    if (pv && m_cap) begin
      wq.push_back('{k + 1, BA_W'(m_wb * (1 << ADDR_W) + m_n), pd});
      m_n++;
      if (m_n == NPIX) begin
        m_cap = 0;
        pend_vis.push_back(k + 2);
        m_wb = (m_wb + 1) % NBANK;
      end
    end
    foreach (pend_vis[i]) if (pend_vis[i] <= k + 1) fr = 1;
    sq.push_back('{k + 1, fr, m_cap, ovr,
                   bit'(NBANK == 2 && (m_acks % 2) == 1)});
  endfunction

  task automatic drive(bit fs, bit pv, logic [PIX_W-1:0] pd, bit ack);
    @(posedge clk);
    #1;
    bus.frame_start = fs;
    bus.pix_valid = pv;
    bus.pix_data = pd;
    bus.frame_ack = ack;
    model_step(fs, pv, pd, ack, cyc);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, PIX_W'($urandom), 1'b0);
  endtask

  task automatic ack();
    drive(1'b0, 1'b0, PIX_W'($urandom), 1'b1);
  endtask

  task automatic frame(int npx, int gap, int base);
    drive(1'b1, 1'b0, PIX_W'($urandom), 1'b0);
    for (int i = 0; i < npx; i++) begin
      drive(1'b0, 1'b1, PIX_W'(base + i), 1'b0);
      idle(gap);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_we"}, 32'(bus.buf_we), 0);
    chk({tag, "_fr"}, 32'(bus.frame_ready), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 0);
    chk({tag, "_addr"}, 32'(bus.buf_addr), 0);
    chk({tag, "_rdb"}, 32'(bus.rd_bank), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.frame_ack = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.buf_we) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_write: got addr %0h data %0h want none at cycle %0d",
                   bus.buf_addr, bus.buf_wdata, cyc);
        end else begin
          mw = wq.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(mw.cyc));
          chk("wr_addr", 32'(bus.buf_addr), 32'(mw.addr));
          chk("wr_data", 32'(bus.buf_wdata), 32'(mw.data));
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_write: got none want addr %0h at cycle %0d",
                 wq[0].addr, cyc);
        void'(wq.pop_front());
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        ms = sq.pop_front();
        chk("frame_ready", 32'(bus.frame_ready), 32'(ms.fr));
        chk("busy", 32'(bus.busy), 32'(ms.busy));
        chk("overrun", 32'(bus.overrun), 32'(ms.ovr));
        chk("rd_bank", 32'(bus.rd_bank), 32'(ms.rdb));
      end
    end
  end

  initial begin
    int r;
    bus.frame_start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.frame_ack = 1'b0;
    model_reset();
    #1;
    check_idle_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // full frame 0x10..0x17
    frame(8, 0, 8'h10);
    idle(3);
    ack();
    idle(2);

    // gapped stream
    frame(8, 1, 8'h40);
    idle(2);
    ack();
    idle(2);

    // restart after 5 pixels
    frame(5, 0, 8'h60);
    frame(8, 0, 8'h70);
    idle(2);
    ack();
    idle(2);

    // hold and drop while ready
    frame(8, 0, 8'h80);
    idle(2);
    frame(8, 0, 8'h90);
    idle(1);
    ack();
    idle(2);
    frame(8, 0, 8'ha0);
    idle(2);
    ack();
    idle(2);

    // reset mid-capture, then a clean frame
    frame(3, 0, 8'hb0);
    do_reset();
    frame(8, 0, 8'hc0);
    idle(2);
    ack();
    idle(2);

`ifdef BUF_PINGPONG_EN
    frame(8, 0, 8'h20);
    idle(1);
    frame(8, 0, 8'h30);
    idle(2);
    frame(8, 0, 8'h50);
    idle(1);
    ack();
    idle(2);
    ack();
    idle(2);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      drive(r < 4, $urandom_range(0, 99) < 60, PIX_W'($urandom),
            $urandom_range(0, 99) < 8);
    end
    idle(4);
    chk("writes_drained", 32'(wq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/img_buf_writer.md
Name: img_buf_writer

Overview:
- Captures the raster pixel stream from the inward-facing camera readout and writes it into the image buffer RAM that pupil_detect reads.
- Counts rows and columns, generates linear write addresses, and signals a complete frame to the consumer.
- Holds each frame until the consumer acknowledges it, so the buffer is never overwritten while pupil_detect is reading it.

Parameters:
- IMG_W, 112, pixels per row
- IMG_H, 112, rows per frame
- PIX_W, 8, pixel data width
- ADDR_W, 14, buffer word address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse marking the start of a camera frame
- pix_valid  in  1  pix_data is valid this cycle
- pix_data  in  PIX_W  pixel value, raster order
- buf_we  out  1  buffer write enable
- buf_addr  out  ADDR_W (ADDR_W+1 with BUF_PINGPONG_EN)  buffer write address
- buf_wdata  out  PIX_W  buffer write data
- frame_ready  out  1  a complete frame is in the buffer
- rd_bank  out  1  bank holding the ready frame (tied 0 without BUF_PINGPONG_EN)
- frame_ack  in  1  consumer has finished with the ready frame
- busy  out  1  capture is in progress
- overrun  out  1  one-cycle pulse on a dropped or truncated frame

Behaviour:
- Reset: async on rst_n low.
  - Outputs cleared: buf_we, buf_addr, buf_wdata, frame_ready, rd_bank, busy and overrun all 0.
  - Internal state: state=IDLE, counters 0.
- States: IDLE, CAPTURE, READY.
- IDLE:
  - pix_valid is ignored.
  - frame_start -> CAPTURE with col=0, row=0, addr=0.
  - If pix_valid is high in the same cycle as frame_start, that pixel is pixel 0 and is written.
- CAPTURE:
  - busy=1.
  - Each pix_valid produces a registered write on the next cycle: buf_we=1, buf_addr=addr, buf_wdata=pix_data.
  - Then addr increments by 1 and col increments.
  - col wraps IMG_W-1 -> 0 and increments row.
  - addr is held as a running counter; no multiplier is used.
- Frame completion:
  - The pixel at row=IMG_H-1, col=IMG_W-1 is the last pixel; after accepting it the block enters READY.
  - frame_ready rises the cycle after the final buf_we.
  - Write latency is exactly 1 cycle from pix_valid to buf_we.
- Extra pixels after the last pixel and before the next frame_start are ignored. No write occurs for them.
- frame_start during CAPTURE:
  - The partial frame is abandoned and overrun pulses.
  - Counters restart at 0, and a coincident pix_valid is written as pixel 0.
- READY:
  - frame_ready=1 and busy=0.
  - frame_ack -> frame_ready drops the next cycle and the state returns to IDLE.
  - frame_start while in READY: the frame is dropped, overrun pulses, and the state stays READY.
  - frame_start and frame_ack in the same cycle: the ack is honoured and the new frame is captured, moving directly to CAPTURE with no overrun.
- frame_ack outside READY is ignored.
- Reset mid-frame: all state clears immediately and any in-flight write is squashed (buf_we=0).

Optional Feature:
- Macro: BUF_PINGPONG_EN.
- With BUF_PINGPONG_EN:
  - Two banks; buf_addr MSB = write bank.
  - On frame completion the completed bank is published on rd_bank with frame_ready=1.
  - Capture may begin at once into the other bank, provided that bank is not awaiting ack.
  - A frame_start is dropped with an overrun pulse only when both banks hold unacknowledged frames.
  - The write bank alternates after each completed frame; an abandoned frame reuses the same bank.
  - The block can be capturing while frame_ready=1, so busy and frame_ready may both be high.
- Without BUF_PINGPONG_EN:
  - Single bank; buf_addr is ADDR_W wide and rd_bank is 0.
  - The block behaves as described in Behaviour.

Test Plan:
- Full frame: IMG_W=4, IMG_H=2, frame_start followed by 8 pix_valid with data 0x10..0x17 -> 8 writes at addr 0..7 with matching data, each 1 cycle after its pixel. frame_ready=1 the cycle after the write to addr 7.
- Gapped stream: pix_valid toggled every other cycle -> addresses remain contiguous 0..7, no writes on idle cycles, and addr 4 corresponds to row 1, col 0.
- Restart: frame_start after 5 pixels -> overrun pulses once and the next pixel is written to addr 0. The frame then completes normally after 8 more pixels.
- Hold and drop: while in READY, frame_start with 8 pixels -> no buf_we and one overrun pulse. Then frame_ack -> frame_ready=0 the next cycle, and a new frame is captured.
- Reset mid-capture: rst_n low after 3 pixels -> buf_we, frame_ready and busy are 0 immediately. After release, the next frame starts at addr 0.
- With BUF_PINGPONG_EN:
  - Two frames captured without any ack -> frame 1 goes to bank 0 (rd_bank=0); frame 2 goes to addresses 0x4000..0x4007.
  - A third frame_start with no ack -> overrun pulse.
  - frame_ack -> rd_bank=1.
